// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory access controller.
// FSM encodings and default widths.
package mem_stage_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic mem_access(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_reg_16bit.sv
// Enabled data register with asynchronous active-high clear.
// Width defaults to 16 bits; it is overridden where the address or data width differs.
module reg_16bit
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one memory request per X/M load/store and freezes the pipeline until acknowledged.
// Optional stall_cnt output is enabled by defining MEM_STALL_CNT_EN.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_memRead,
    input  logic              M_memWrite,
    input  logic [ADDR_W-1:0] M_aluOut,
    input  logic [DATA_W-1:0] M_regData2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] M_memData,
    output logic              err
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       start;
    logic       rd_ack;
    logic       stray_ack;
    logic       both_ops;

    assign start     = (state == ST_IDLE) && mem_access(M_memRead, M_memWrite);
    assign rd_ack    = (state == ST_BUSY) && mem_valid && !mem_we;
    assign stray_ack = mem_valid && (state != ST_BUSY);
    assign both_ops  = M_memRead && M_memWrite;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_BUSY;
            ST_BUSY: if (mem_valid) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mem_we <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                mem_we <= M_memWrite;
            end
            if (stray_ack || (start && both_ops)) begin
                err <= 1'b1;
            end
        end
    end

    assign mem_req = (state == ST_BUSY);
    // Reset forces stall low at once, even while a load/store is still presented in IDLE.
    assign stall   = !rst && (start || (state == ST_BUSY));

    reg_16bit #(.W(ADDR_W)) u_addr_reg (
        .clk (clk),
        .rst (rst),
        .wen (start),
        .d   (M_aluOut),
        .q   (mem_addr)
    );

    reg_16bit #(.W(DATA_W)) u_wdata_reg (
        .clk (clk),
        .rst (rst),
        .wen (start),
        .d   (M_regData2),
        .q   (mem_wdata)
    );

    reg_16bit #(.W(DATA_W)) u_rdata_reg (
        .clk (clk),
        .rst (rst),
        .wen (rd_ack),
        .d   (mem_rdata),
        .q   (M_memData)
    );

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
